ysyx_24100012_alu_issue: RTL and testbench

Decode and issue stage that drives the ALU. It takes a fetched RV32I instruction plus its PC and register-file read values, decodes opcode/funct3/funct7 into the 4-bit ALU select and instruction type, and muxes the operands (rs1/PC/zero, rs2/immediate/4). Results sit in a registered valid/ready output stage with a one-entry skid buffer between IFU/regfile and EXU.

---
 rtl/ysyx_24100012_alu_issue.sv | 243 ++++++++++++++++++++++++
 tb/tb_ysyx_24100012_alu_issue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_alu_issue.sv
// RV32I decode/issue stage feeding the ALU: decode, operand mux, registered output plus one-entry skid.
// Optional build macro ALU_ISSUE_STAT_EN adds the stat_issued / stat_stall counter ports.
`timescale 1ns/1ps
module ysyx_24100012_alu_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [SEL_W-1:0]      out_alu_sel,
  output logic [2:0]            out_inst_type,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_illegal
`ifdef ALU_ISSUE_STAT_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  // Valid/ready: a transfer happens on any rising edge where valid && ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] TYPE_R   = 3'd0;
  localparam logic [2:0] TYPE_I   = 3'd1;
  localparam logic [2:0] TYPE_S   = 3'd2;
  localparam logic [2:0] TYPE_B   = 3'd3;
  localparam logic [2:0] TYPE_U   = 3'd4;
  localparam logic [2:0] TYPE_J   = 3'd5;
  localparam logic [2:0] TYPE_SYS = 3'd6;
  localparam logic [2:0] TYPE_ILL = 3'd7;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [SEL_W-1:0]      sel;
    logic [2:0]            itype;
    logic                  illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic        legal;
  entry_t      dec;
  logic        unused_rs1_idx;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_u  = {in_inst[31:12], 12'b0};
  // Register indices are resolved upstream; only the read values arrive here.
  assign unused_rs1_idx = ^in_inst[19:15];

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    legal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.itype = TYPE_R;
        dec.sel   = {funct7[5], funct3};
        dec.a     = in_rs1_val;
        dec.b     = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, in_rs2_val[4:0]} : in_rs2_val;
        legal     = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OPIMM: begin
        dec.itype = TYPE_I;
        dec.sel   = {1'b0, funct3};
        dec.a     = in_rs1_val;
        dec.b     = imm_i;
        if (funct3 == 3'b001) begin
          dec.b = {27'b0, in_inst[24:20]};
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.b   = {27'b0, in_inst[24:20]};
          dec.sel = {in_inst[30], 3'b101};
          legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      end
      OPC_LOAD: begin
        dec.itype = TYPE_I;
        dec.a     = in_rs1_val;
        dec.b     = imm_i;
      end
      OPC_STORE: begin
        dec.itype = TYPE_S;
        dec.a     = in_rs1_val;
        dec.b     = imm_s;
      end
      OPC_BRANCH: begin
        dec.itype = TYPE_B;
        dec.a     = in_rs1_val;
        dec.b     = in_rs2_val;
        case (funct3[2:1])
          2'b00:   dec.sel = 4'b1000;
          2'b10:   dec.sel = 4'b0010;
          2'b11:   dec.sel = 4'b0011;
          default: legal   = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.itype = TYPE_U;
        dec.b     = imm_u;
      end
      OPC_AUIPC: begin
        dec.itype = TYPE_U;
        dec.a     = in_pc;
        dec.b     = imm_u;
      end
      OPC_JAL: begin
        dec.itype = TYPE_J;
        dec.a     = in_pc;
        dec.b     = 32'd4;
      end
      OPC_JALR: begin
        dec.itype = TYPE_I;
        dec.a     = in_pc;
        dec.b     = 32'd4;
        legal     = (funct3 == 3'b000);
      end
      OPC_SYSTEM: dec.itype = TYPE_SYS;
      default:    legal = 1'b0;
    endcase
    // Illegal entries still flow through the pipe, but with neutral operands.
    if (!legal) begin
      dec.a     = '0;
      dec.b     = '0;
      dec.sel   = '0;
      dec.itype = TYPE_ILL;
    end
    dec.illegal = ~legal;
  end

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   out_fire;

  assign accept   = in_valid & ~skid_valid_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full means in_ready is low, so only draining can happen.
      if (out_fire) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = accept;
      if (accept) out_d = dec;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready      = ~skid_valid_q;
  assign out_valid     = out_valid_q;
  assign out_a         = out_q.a;
  assign out_b         = out_q.b;
  assign out_alu_sel   = out_q.sel;
  assign out_inst_type = out_q.itype;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.illegal;

`ifdef ALU_ISSUE_STAT_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q + {31'b0, out_fire};
    stat_stall_d  = stat_stall_q + {31'b0, in_valid & skid_valid_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_24100012_alu_issue.sv
// Bench for ysyx_24100012_alu_issue: decode vector table, stall/skid, flush and async reset sequences.
`timescale 1ns/1ps
module tb_ysyx_24100012_alu_issue;
  localparam int W = 104;
  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_sel;
  logic [2:0]  out_inst_type;
  logic [31:0] out_pc;
  logic        out_illegal;
`ifdef ALU_ISSUE_STAT_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  ysyx_24100012_alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_alu_sel(out_alu_sel), .out_inst_type(out_inst_type), .out_pc(out_pc),
    .out_illegal(out_illegal)
`ifdef ALU_ISSUE_STAT_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst, pc, rs1, rs2, a, b;
    logic [3:0]  sel;
    logic [2:0]  ty;
    logic        ill;
  } vec_t;

  vec_t vecs[NV];
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int issued_cnt = 0;
  int stall_cnt = 0;

  function automatic vec_t mk(input logic [31:0] inst, pc, rs1, rs2, a, b,
                              input logic [3:0] sel, input logic [2:0] ty, input logic ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.a = a; v.b = b; v.sel = sel; v.ty = ty; v.ill = ill;
    return v;
  endfunction

  function automatic logic [W-1:0] pack_exp(input vec_t v);
    return {v.pc, v.a, v.b, v.sel, v.ty, v.ill};
  endfunction

  logic [W-1:0] dut_word;
  assign dut_word = {out_pc, out_a, out_b, out_alu_sel, out_inst_type, out_illegal};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // scoreboard: pop and compare on each issue
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue: got %h required nothing", dut_word);
      end else begin
        check("issue", dut_word, exp_q.pop_front());
        issued_cnt++;
      end
    end
    if (rst && in_valid && !in_ready) stall_cnt++;
  end

  // driver: hold one entry until it handshakes; with fl set it is offered alongside flush and dropped
  task automatic send(input vec_t v, input bit fl);
    int waited = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_inst = v.inst; in_pc = v.pc;
    in_rs1_val = v.rs1; in_rs2_val = v.rs2; flush = fl;
    while (!done) begin
      @(negedge clk);
      if (fl) done = 1'b1;
      else if (in_ready) begin
        exp_q.push_back(pack_exp(v));
        done = 1'b1;
      end else if (++waited > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 50 cycles");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (fl) exp_q.delete();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    int c0;
    vecs[0]  = mk(32'hFFF10093, 32'h1000, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 4'b0000, 3'd1, 1'b0);
    vecs[1]  = mk(32'h40208033, 32'h1004, 32'd9, 32'd3, 32'd9, 32'd3, 4'b1000, 3'd0, 1'b0);
    vecs[2]  = mk(32'h4030D093, 32'h1008, 32'h80000000, 32'd7, 32'h80000000, 32'd3, 4'b1101, 3'd1, 1'b0);
    vecs[3]  = mk(32'h12345037, 32'h100C, 32'hDEADBEEF, 32'd1, 32'd0, 32'h12345000, 4'b0000, 3'd4, 1'b0);
    vecs[4]  = mk(32'h0000000B, 32'h1010, 32'd1, 32'd2, 32'd0, 32'd0, 4'b0000, 3'd7, 1'b1);
    vecs[5]  = mk(32'h023110B3, 32'h1014, 32'd1, 32'd2, 32'd0, 32'd0, 4'b0000, 3'd7, 1'b1);
    vecs[6]  = mk(32'h003110B3, 32'h1018, 32'd1, 32'hFFFFFF25, 32'd1, 32'd5, 4'b0001, 3'd0, 1'b0);
    vecs[7]  = mk(32'h00001097, 32'h80000000, 32'd3, 32'd4, 32'h80000000, 32'h1000, 4'b0000, 3'd4, 1'b0);
    vecs[8]  = mk(32'h000000EF, 32'h100, 32'd3, 32'd4, 32'h100, 32'd4, 4'b0000, 3'd5, 1'b0);
    vecs[9]  = mk(32'h000100E7, 32'h200, 32'h55, 32'd4, 32'h200, 32'd4, 4'b0000, 3'd1, 1'b0);
    vecs[10] = mk(32'hFE312E23, 32'h1028, 32'h1000, 32'h77, 32'h1000, 32'hFFFFFFFC, 4'b0000, 3'd2, 1'b0);
    vecs[11] = mk(32'h00812083, 32'h102C, 32'h2000, 32'd1, 32'h2000, 32'd8, 4'b0000, 3'd1, 1'b0);
    vecs[12] = mk(32'h0020E063, 32'h1030, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 4'b0011, 3'd3, 1'b0);
    vecs[13] = mk(32'h00208063, 32'h1034, 32'd4, 32'd4, 32'd4, 32'd4, 4'b1000, 3'd3, 1'b0);
    vecs[14] = mk(32'h0020A063, 32'h1038, 32'd4, 32'd4, 32'd0, 32'd0, 4'b0000, 3'd7, 1'b1);
    vecs[15] = mk(32'h00000073, 32'h103C, 32'd9, 32'd9, 32'd0, 32'd0, 4'b0000, 3'd6, 1'b0);
    vecs[16] = mk(32'hFFE12093, 32'h1040, 32'd3, 32'd0, 32'd3, 32'hFFFFFFFE, 4'b0010, 3'd1, 1'b0);
    vecs[17] = mk(32'h40011093, 32'h1044, 32'd3, 32'd0, 32'd0, 32'd0, 4'b0000, 3'd7, 1'b1);
    vecs[18] = mk(32'h0F017093, 32'h1048, 32'hFF, 32'd0, 32'hFF, 32'hF0, 4'b0111, 3'd1, 1'b0);
    vecs[19] = mk(32'h4020D0B3, 32'h104C, 32'hF0000000, 32'h24, 32'hF0000000, 32'd4, 4'b1101, 3'd0, 1'b0);

    // reset state
    #12;
    check("reset_payload", dut_word, '0);
    check("reset_valid_ready", W'({out_valid, in_ready}), W'(2'b01));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // full table back to back with out_ready high: one accept per cycle, no bubbles
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(vecs[i], 1'b0);
    check("throughput_cycles", W'(cyc - c0), W'(NV));
    @(posedge clk);
    #1;
    check("latency_drain", W'(exp_q.size()), '0);

    // stall: two accepted, third held off until the output drains
    out_ready = 1'b0;
    send(vecs[1], 1'b0);
    send(vecs[2], 1'b0);
    fork
      send(vecs[3], 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("stall_in_ready", W'(in_ready), '0);
        check("stall_out_valid", W'(out_valid), W'(1'b1));
        check("stall_hold", dut_word, pack_exp(vecs[1]));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("skid_drained_ready", W'(in_ready), W'(1'b1));
    @(posedge clk);
    #1;
    check("stall_drain_q", W'(exp_q.size()), '0);
    check("stall_drain_valid", W'({out_valid, in_ready}), W'(2'b01));

    // flush with output and skid both full, input offered
    out_ready = 1'b0;
    send(vecs[4], 1'b0);
    send(vecs[5], 1'b0);
    send(vecs[6], 1'b1);
    check("flush_full", W'({out_valid, in_ready}), W'(2'b01));
    // flush while a handshake happens: that entry is dropped too
    send(vecs[7], 1'b0);
    send(vecs[8], 1'b1);
    check("flush_handshake", W'({out_valid, in_ready}), W'(2'b01));
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_ghost", W'(out_valid), '0);
    send(vecs[9], 1'b0);
    @(posedge clk);
    #1;
    check("post_flush_drain", W'(exp_q.size()), '0);

`ifdef ALU_ISSUE_STAT_EN
    check("stat_issued", W'(stat_issued), W'(issued_cnt));
    check("stat_stall", W'(stat_stall), W'(stall_cnt));
`endif

    // async reset in the middle of a stall
    out_ready = 1'b0;
    send(vecs[10], 1'b0);
    send(vecs[11], 1'b0);
    in_valid = 1'b1; in_inst = vecs[12].inst; in_pc = vecs[12].pc;
    in_rs1_val = vecs[12].rs1; in_rs2_val = vecs[12].rs2;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_payload", dut_word, '0);
    check("async_reset_valid_ready", W'({out_valid, in_ready}), W'(2'b01));
`ifdef ALU_ISSUE_STAT_EN
    check("async_reset_stats", W'({stat_issued, stat_stall}), '0);
`endif
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
